// File: rtl/mri_rd_arb.sv
// Mesh Read Interface read arbiter: round-robin share of one MIM read request
// channel among CPB/TMU/PRC, read-ID allocation and response routing by ID.
module mri_rd_arb #(
  parameter int ADDR_W = 20,
  parameter int TAG_W  = 6,
  parameter int ID_W   = 4,
  parameter int DATA_W = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*TAG_W-1:0]  req_tag,
  output logic                mim_req_valid,
  input  logic                mim_req_ready,
  output logic [ADDR_W-1:0]   mim_req_addr,
  output logic [ID_W-1:0]     mim_req_id,
  input  logic                mim_rsp_valid,
  input  logic [ID_W-1:0]     mim_rsp_id,
  input  logic [DATA_W-1:0]   mim_rsp_data,
  output logic [2:0]          rsp_valid,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [ID_W:0]       outst_cnt,
  output logic                err_spurious
);

  localparam int DEPTH = 2**ID_W;

  logic [DEPTH-1:0] free_map;
  logic [1:0]       last;
  logic [1:0]       tbl_src [DEPTH];
  logic [TAG_W-1:0] tbl_tag [DEPTH];

  logic             gnt;
  logic [1:0]       gnt_port;
  logic [ID_W-1:0]  alloc_id;
  logic             rsp_hit;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] rel_mask;

  always_comb begin
    gnt      = 1'b0;
    gnt_port = '0;
    alloc_id = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      int unsigned p;
      p = (int'(last) + k) % 3;
      if (!gnt && req_valid[p]) begin
        gnt      = 1'b1;
        gnt_port = 2'(p);
      end
    end
    if ((mim_req_valid && !mim_req_ready) || (free_map == '0))
      gnt = 1'b0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (free_map[i-1]) alloc_id = ID_W'(i-1);
    end
    req_ready  = gnt ? (3'b001 << gnt_port) : '0;
    rsp_hit    = mim_rsp_valid && !free_map[mim_rsp_id];
    alloc_mask = gnt ? (DEPTH'(1) << alloc_id) : '0;
    rel_mask   = rsp_hit ? (DEPTH'(1) << mim_rsp_id) : '0;
  end

  // A released ID is only reselectable next cycle: allocation above sees the
  // pre-update bitmap, and a live ID can never equal the lowest free one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_map      <= '1;
      last          <= 2'd2;
      mim_req_valid <= 1'b0;
      mim_req_addr  <= '0;
      mim_req_id    <= '0;
      rsp_valid     <= '0;
      rsp_tag       <= '0;
      rsp_data      <= '0;
      outst_cnt     <= '0;
      err_spurious  <= 1'b0;
    end else begin
      free_map <= (free_map & ~alloc_mask) | rel_mask;
      if (gnt) begin
        last          <= gnt_port;
        mim_req_valid <= 1'b1;
        mim_req_addr  <= req_addr[gnt_port*ADDR_W +: ADDR_W];
        mim_req_id    <= alloc_id;
      end else if (mim_req_ready) begin
        mim_req_valid <= 1'b0;
      end
      rsp_valid <= rsp_hit ? (3'b001 << tbl_src[mim_rsp_id]) : '0;
      if (rsp_hit) begin
        rsp_tag  <= tbl_tag[mim_rsp_id];
        rsp_data <= mim_rsp_data;
      end
      err_spurious <= mim_rsp_valid && free_map[mim_rsp_id];
      if (gnt && !rsp_hit)
        outst_cnt <= outst_cnt + (ID_W+1)'(1);
      else if (!gnt && rsp_hit)
        outst_cnt <= outst_cnt - (ID_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) begin
      tbl_src[alloc_id] <= gnt_port;
      tbl_tag[alloc_id] <= req_tag[gnt_port*TAG_W +: TAG_W];
    end
  end

endmodule

// File: tb/tb_mri_rd_arb.sv
// Bench for mri_rd_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a set-based reference model.
module tb_mri_rd_arb;
  localparam int ADDR_W = 20;
  localparam int TAG_W  = 6;
  localparam int ID_W   = 4;
  localparam int DATA_W = 512;
  localparam int DEPTH  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          req_valid = '0;
  logic [2:0]          req_ready;
  logic [3*ADDR_W-1:0] req_addr = '0;
  logic [3*TAG_W-1:0]  req_tag = '0;
  logic                mim_req_valid;
  logic                mim_req_ready = 1'b0;
  logic [ADDR_W-1:0]   mim_req_addr;
  logic [ID_W-1:0]     mim_req_id;
  logic                mim_rsp_valid = 1'b0;
  logic [ID_W-1:0]     mim_rsp_id = '0;
  logic [DATA_W-1:0]   mim_rsp_data = '0;
  logic [2:0]          rsp_valid;
  logic [TAG_W-1:0]    rsp_tag;
  logic [DATA_W-1:0]   rsp_data;
  logic [ID_W:0]       outst_cnt;
  logic                err_spurious;

  mri_rd_arb #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_tag(req_tag), .mim_req_valid(mim_req_valid),
    .mim_req_ready(mim_req_ready), .mim_req_addr(mim_req_addr), .mim_req_id(mim_req_id),
    .mim_rsp_valid(mim_rsp_valid), .mim_rsp_id(mim_rsp_id), .mim_rsp_data(mim_rsp_data),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .outst_cnt(outst_cnt), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: set of free IDs, owner/tag per live ID, last winner,
  // the pending mesh request, and the response expected next cycle.
  bit [DEPTH-1:0]    m_free;
  int                m_src [DEPTH];
  logic [TAG_W-1:0]  m_tag [DEPTH];
  int                m_last;
  bit                m_mv;
  logic [ADDR_W-1:0] m_maddr;
  int                m_mid;
  logic [2:0]        exp_rv;
  logic [TAG_W-1:0]  exp_tag;
  logic [DATA_W-1:0] exp_data;
  bit                exp_err;
  int                m_g;
  int                m_id;
  int                sent [$];
  logic [2:0]        obs_ready;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_free = '1; m_last = 2; m_mv = 0; m_maddr = '0; m_mid = 0;
    exp_rv = '0; exp_tag = '0; exp_data = '0; exp_err = 0;
    sent.delete();
  endtask

  task automatic cycle();
    int ones;
    @(negedge clk);
    m_g = -1;
    if ((!m_mv || mim_req_ready) && m_free != '0)
      for (int k = 1; k <= 3; k++)
        if (m_g < 0 && req_valid[(m_last + k) % 3]) m_g = (m_last + k) % 3;
    m_id = -1;
    for (int i = 0; i < DEPTH; i++) if (m_id < 0 && m_free[i]) m_id = i;
    ones = $countones(m_free);
    obs_ready = req_ready;
    chk("req_ready", req_ready, (m_g >= 0) ? (3'b001 << m_g) : 3'b000);
    chk("mim_req_valid", mim_req_valid, m_mv);
    if (m_mv) begin
      chk("mim_req_addr", mim_req_addr, m_maddr);
      chk("mim_req_id", mim_req_id, m_mid);
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != 0) begin
      chk("rsp_tag", rsp_tag, exp_tag);
      chk("rsp_data", rsp_data, exp_data);
    end
    chk("outst_cnt", outst_cnt, DEPTH - ones);
    chk("err_spurious", err_spurious, exp_err);
    @(posedge clk);
    if (m_mv && mim_req_ready) sent.push_back(m_mid);
    exp_rv = '0; exp_err = 0;
    if (mim_rsp_valid) begin
      if (!m_free[mim_rsp_id]) begin
        exp_rv   = 3'b001 << m_src[mim_rsp_id];
        exp_tag  = m_tag[mim_rsp_id];
        exp_data = mim_rsp_data;
        m_free[mim_rsp_id] = 1'b1;
      end else begin
        exp_err = 1;
      end
    end
    if (m_g >= 0) begin
      m_free[m_id] = 1'b0;
      m_src[m_id]  = m_g;
      m_tag[m_id]  = req_tag[m_g*TAG_W +: TAG_W];
      m_last       = m_g;
      m_mv         = 1;
      m_maddr      = req_addr[m_g*ADDR_W +: ADDR_W];
      m_mid        = m_id;
    end else if (mim_req_ready) begin
      m_mv = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; mim_rsp_valid = 0; mim_req_ready = 0;
    rst = 1; model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic set_req(input int p, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
    req_addr[p*ADDR_W +: ADDR_W] = a;
    req_tag[p*TAG_W +: TAG_W]    = t;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  logic [ADDR_W-1:0] hold_addr;
  logic [ID_W-1:0]   hold_id;

  initial begin
    // Single TMU request, response routed back with its tag
    do_reset();
    chk("rst_mim_valid", mim_req_valid, 0);
    chk("rst_mim_addr", mim_req_addr, 0);
    chk("rst_mim_id", mim_req_id, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_err", err_spurious, 0);
    set_req(1, 20'h00ABC, 6'd5); req_valid = 3'b010; mim_req_ready = 1;
    cycle();
    chk("t1_ready", obs_ready, 3'b010);
    req_valid = '0;
    chk("t1_mim_valid", mim_req_valid, 1);
    chk("t1_mim_id", mim_req_id, 0);
    chk("t1_mim_addr", mim_req_addr, 20'h00ABC);
    mim_rsp_valid = 1; mim_rsp_id = 0; mim_rsp_data = rnd_data();
    cycle();
    mim_rsp_valid = 0;
    chk("t1_rsp_valid", rsp_valid, 3'b010);
    chk("t1_rsp_tag", rsp_tag, 5);
    chk("t1_outst", outst_cnt, 0);
    cycle();

    // Fairness with all three continuously valid
    do_reset();
    set_req(0, 20'h11111, 6'd1); set_req(1, 20'h22222, 6'd2); set_req(2, 20'h33333, 6'd3);
    req_valid = 3'b111; mim_req_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t2_grant", obs_ready, 3'b001 << (i % 3));
      chk("t2_id", mim_req_id, i);
    end
    req_valid = '0;
    cycle();

    // Fill all 16 IDs, then free id 7 and see it reused
    do_reset();
    req_valid = 3'b001; mim_req_ready = 1;
    for (int i = 0; i < 18; i++) begin
      set_req(0, ADDR_W'(i), TAG_W'(i));
      cycle();
    end
    chk("t3_full_cnt", outst_cnt, 16);
    chk("t3_full_ready", obs_ready, 0);
    mim_rsp_valid = 1; mim_rsp_id = 7; mim_rsp_data = rnd_data();
    cycle();
    mim_rsp_valid = 0;
    chk("t3_free_ready", obs_ready, 0);
    cycle();
    chk("t3_regrant", obs_ready, 3'b001);
    chk("t3_reuse_id", mim_req_id, 7);
    chk("t3_reuse_valid", mim_req_valid, 1);
    req_valid = '0;
    cycle();

    // Output stall holds the request and grants nothing more
    do_reset();
    set_req(2, 20'h5A5A5, 6'd9); req_valid = 3'b100; mim_req_ready = 0;
    cycle();
    hold_addr = mim_req_addr; hold_id = mim_req_id;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t4_stall_ready", obs_ready, 0);
      chk("t4_stall_addr", mim_req_addr, hold_addr);
      chk("t4_stall_id", mim_req_id, hold_id);
      chk("t4_stall_cnt", outst_cnt, 1);
    end
    req_valid = '0; mim_req_ready = 1;
    cycle();
    chk("t4_release", mim_req_valid, 0);
    chk("t4_cnt", outst_cnt, 1);

    // Spurious response, then same-cycle accept and release
    mim_rsp_valid = 1; mim_rsp_id = 9; mim_rsp_data = rnd_data();
    cycle();
    mim_rsp_valid = 0;
    chk("t5_err", err_spurious, 1);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_cnt", outst_cnt, 1);
    cycle();
    chk("t5_err_pulse", err_spurious, 0);
    set_req(0, 20'h00042, 6'd7); req_valid = 3'b001;
    mim_rsp_valid = 1; mim_rsp_id = 0; mim_rsp_data = rnd_data();
    cycle();
    mim_rsp_valid = 0; req_valid = '0;
    chk("t5_same_cnt", outst_cnt, 1);
    chk("t5_same_id", mim_req_id, 1);
    chk("t5_same_rsp", rsp_valid, 3'b100);

    // Asynchronous reset with three IDs outstanding
    req_valid = 3'b010;
    cycle(); cycle();
    req_valid = '0;
    cycle();
    chk("t6_cnt", outst_cnt, 3);
    #2; rst = 1; model_reset(); #1;
    chk("t6_mim_valid", mim_req_valid, 0);
    chk("t6_mim_addr", mim_req_addr, 0);
    chk("t6_outst", outst_cnt, 0);
    chk("t6_rsp_data", rsp_data, 0);
    @(posedge clk); #1; rst = 0;
    req_valid = 3'b111; mim_req_ready = 1;
    mim_rsp_valid = 1; mim_rsp_id = 1; mim_rsp_data = rnd_data();
    cycle();
    mim_rsp_valid = 0; req_valid = '0;
    chk("t6_first_grant", obs_ready, 3'b001);
    chk("t6_first_id", mim_req_id, 0);
    chk("t6_stale_err", err_spurious, 1);
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      cycle();
      for (int p = 0; p < 3; p++) begin
        if (req_valid[p] && m_g == p) req_valid[p] = 1'b0;
        if (!req_valid[p] && ($urandom % 3 == 0)) begin
          set_req(p, ADDR_W'($urandom), TAG_W'($urandom));
          req_valid[p] = 1'b1;
        end
      end
      mim_req_ready = ($urandom % 4) != 0;
      mim_rsp_valid = 0;
      r = $urandom % 100;
      if (r < 40 && sent.size() > 0) begin
        int j;
        j = $urandom % sent.size();
        mim_rsp_id = ID_W'(sent[j]);
        sent.delete(j);
        mim_rsp_valid = 1;
      end else if (r < 46) begin
        int id;
        id = $urandom % DEPTH;
        if (m_free[id]) begin
          mim_rsp_id = ID_W'(id);
          mim_rsp_valid = 1;
        end
      end
      mim_rsp_data = rnd_data();
    end
    req_valid = '0; mim_rsp_valid = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
